// File: rtl/muldiv_sequencer_pkg.sv
// Shared ISA opcode encodings and mul/div helpers.
// Imported by the control unit and the mul/div sequencer.
package muldiv_sequencer_pkg;

    localparam int OP_W = 3;

    localparam logic [OP_W-1:0] OPC_DIV  = 3'b000;
    localparam logic [OP_W-1:0] OPC_MULI = 3'b001;
    localparam logic [OP_W-1:0] OPC_DIVI = 3'b010;
    localparam logic [OP_W-1:0] OPC_MUL  = 3'b111;

    typedef enum logic {
        KIND_MUL = 1'b0,
        KIND_DIV = 1'b1
    } md_kind_e;

    function automatic logic is_muldiv(input logic [OP_W-1:0] op);
        return (op == OPC_MUL) || (op == OPC_MULI) ||
               (op == OPC_DIV) || (op == OPC_DIVI);
    endfunction

    function automatic md_kind_e decode_kind(input logic [OP_W-1:0] op);
        return ((op == OPC_DIV) || (op == OPC_DIVI)) ? KIND_DIV : KIND_MUL;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One radix-2 iteration: shift-add multiply or restoring divide.
// Purely combinational; the sequencer owns every register.
module muldiv_step
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  md_kind_e               mode,
    input  logic [2*WIDTH-1:0]     acc,
    input  logic [WIDTH-1:0]       operand,
    output logic [2*WIDTH-1:0]     acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic             fits;
    logic [WIDTH-1:0] rem_sub;

    // Multiply: add multiplicand on LSB=1, shift right. Divide: shift in
    // dividend MSB, keep the difference only when it does not go negative.
    always_comb begin
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]}
                 + (acc[0] ? {1'b0, operand} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        fits     = (shifted >= {1'b0, operand});
        rem_sub  = shifted[WIDTH-1:0] - operand;
        acc_next = '0;
        if (mode == KIND_MUL) begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end else if (fits) begin
            acc_next = {rem_sub, acc[WIDTH-2:0], 1'b1};
        end else begin
            acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply/divide controller, one bit per clock.
// Accumulator upper half holds product-high/remainder, lower half product-low/quotient.
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int OP_WIDTH = OP_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [OP_WIDTH-1:0] opcode,
    input  logic [WIDTH-1:0]    operand_a,
    input  logic [WIDTH-1:0]    operand_b,
    output logic                busy,
    output logic                done,
    output logic [WIDTH-1:0]    result_low,
    output logic [WIDTH-1:0]    result_high,
    output logic                zero,
    output logic                overflow,
    output logic                div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state;
    md_kind_e             kind;
    md_kind_e             new_kind;
    logic [WIDTH-1:0]     operand;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_next;
    logic [CW-1:0]        cnt;
    logic                 accept;
    logic                 last;

    assign new_kind = decode_kind(opcode);
    assign accept   = start && (state != S_RUN) && is_muldiv(opcode);
    assign last     = (cnt == CW'(WIDTH - 1));
    assign busy     = (state == S_RUN);
    assign done     = (state == S_DONE);

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .mode     (kind),
        .acc      (acc),
        .operand  (operand),
        .acc_next (acc_next)
    );

    // Sequencer FSM: launch, iterate, and register results on entry to DONE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            kind        <= KIND_MUL;
            operand     <= '0;
            acc         <= '0;
            cnt         <= '0;
            result_low  <= '0;
            result_high <= '0;
            zero        <= 1'b0;
            overflow    <= 1'b0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            kind    <= new_kind;
            cnt     <= '0;
            if (new_kind == KIND_MUL) begin
                operand <= operand_a;
                acc     <= {{WIDTH{1'b0}}, operand_b};
            end else begin
                operand <= operand_b;
                acc     <= {{WIDTH{1'b0}}, operand_a};
            end
            if (new_kind == KIND_DIV && operand_b == '0) begin
                state       <= S_DONE;
                result_low  <= '1;
                result_high <= operand_a;
                zero        <= 1'b0;
                overflow    <= 1'b0;
                div_by_zero <= 1'b1;
            end else begin
                state <= S_RUN;
            end
        end else begin
            unique case (state)
                S_RUN: begin
                    acc <= acc_next;
                    cnt <= cnt + 1'b1;
                    if (last) begin
                        state       <= S_DONE;
                        result_low  <= acc_next[WIDTH-1:0];
                        result_high <= acc_next[2*WIDTH-1:WIDTH];
                        zero        <= (acc_next[WIDTH-1:0] == '0);
                        overflow    <= (kind == KIND_MUL) &&
                                       (acc_next[2*WIDTH-1:WIDTH] != '0);
                        div_by_zero <= 1'b0;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: arithmetic reference model checked every
// cycle, plus literal expectations from hand-worked operations.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  opcode;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] result_low;
    logic [15:0] result_high;
    logic        zero;
    logic        overflow;
    logic        div_by_zero;

    int tests = 0;
    int fails = 0;

    muldiv_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .opcode      (opcode),
        .operand_a   (op_a),
        .operand_b   (op_b),
        .busy        (busy),
        .done        (done),
        .result_low  (result_low),
        .result_high (result_high),
        .zero        (zero),
        .overflow    (overflow),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Reference model: operation latency and results from plain arithmetic.
    int          m_left = 0;
    bit          m_done = 0;
    logic [15:0] m_lo = 0, m_hi = 0;
    bit          m_zero = 0, m_ov = 0, m_dbz = 0;
    logic [15:0] p_lo, p_hi;
    bit          p_ov;
    logic [31:0] prod;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0; m_done = 0;
            m_lo = 0; m_hi = 0; m_zero = 0; m_ov = 0; m_dbz = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_done = 1;
                m_lo = p_lo; m_hi = p_hi;
                m_zero = (p_lo == 0); m_ov = p_ov; m_dbz = 0;
            end
        end else begin
            m_done = 0;
            if (start && (opcode == 3'b111 || opcode == 3'b001)) begin
                prod = 32'(op_a) * 32'(op_b);
                p_lo = prod[15:0];
                p_hi = prod[31:16];
                p_ov = (p_hi != 0);
                m_left = 16;
            end else if (start && (opcode == 3'b000 || opcode == 3'b010)) begin
                if (op_b == 0) begin
                    m_done = 1;
                    m_lo = 16'hFFFF; m_hi = op_a;
                    m_zero = 0; m_ov = 0; m_dbz = 1;
                end else begin
                    p_lo = op_a / op_b;
                    p_hi = op_a % op_b;
                    p_ov = 0;
                    m_left = 16;
                end
            end
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_left > 0));
        chk("done", 32'(done), 32'(m_done));
        chk("result_low", 32'(result_low), 32'(m_lo));
        chk("result_high", 32'(result_high), 32'(m_hi));
        chk("zero", 32'(zero), 32'(m_zero));
        chk("overflow", 32'(overflow), 32'(m_ov));
        chk("div_by_zero", 32'(div_by_zero), 32'(m_dbz));
    end

    task automatic issue(input logic [2:0] op, input logic [15:0] a,
                         input logic [15:0] b);
        start = 1; opcode = op; op_a = a; op_b = b;
    endtask

    // Counts cycles after the issuing cycle until done; 0 on timeout.
    task automatic wait_done(input int limit, input int inject,
                             output int n, output bit saw_busy);
        n = 0;
        saw_busy = 0;
        for (int i = 1; i <= limit; i++) begin
            @(negedge clk);
            if (i == 1) start = 0;
            if (i == inject) issue(3'b111, 16'h00AA, 16'h0055);
            if (i == inject + 1) start = 0;
            if (busy) saw_busy = 1;
            if (done) begin
                n = i;
                return;
            end
        end
    endtask

    int n;
    bit sb;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1; start = 0; opcode = 3'b011; op_a = 0; op_b = 0;
        repeat (2) @(negedge clk);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_low", 32'(result_low), 0);
        rst = 0;

        @(negedge clk);
        issue(3'b111, 16'd300, 16'd300);
        wait_done(40, 0, n, sb);
        chk("mul_cycle", n, 17);
        chk("mul_low", 32'(result_low), 32'h5F90);
        chk("mul_high", 32'(result_high), 32'h0001);
        chk("mul_ovf", 32'(overflow), 1);
        chk("mul_zero", 32'(zero), 0);

        @(negedge clk);
        issue(3'b010, 16'd1000, 16'd7);
        wait_done(40, 0, n, sb);
        chk("divi_cycle", n, 17);
        chk("divi_quot", 32'(result_low), 142);
        chk("divi_rem", 32'(result_high), 6);
        chk("divi_ovf", 32'(overflow), 0);
        chk("divi_dbz", 32'(div_by_zero), 0);

        @(negedge clk);
        issue(3'b000, 16'h1234, 16'd0);
        wait_done(40, 0, n, sb);
        chk("dbz_cycle", n, 1);
        chk("dbz_nobusy", 32'(sb), 0);
        chk("dbz_low", 32'(result_low), 32'hFFFF);
        chk("dbz_high", 32'(result_high), 32'h1234);
        chk("dbz_flag", 32'(div_by_zero), 1);

        @(negedge clk);
        issue(3'b011, 16'd5, 16'd5);
        wait_done(20, 0, n, sb);
        chk("lui_nodone", n, 0);
        chk("lui_nobusy", 32'(sb), 0);
        chk("lui_hold", 32'(result_high), 32'h1234);

        @(negedge clk);
        issue(3'b111, 16'd1234, 16'd56);
        wait_done(40, 5, n, sb);
        chk("inj_cycle", n, 17);
        chk("inj_low", 32'(result_low), 32'h0DF0);
        chk("inj_high", 32'(result_high), 32'h0001);

        @(negedge clk);
        issue(3'b001, 16'd0, 16'd5);
        wait_done(40, 0, n, sb);
        chk("b2b1_cycle", n, 17);
        chk("b2b1_low", 32'(result_low), 0);
        chk("b2b1_zero", 32'(zero), 1);
        issue(3'b000, 16'd9, 16'd3);
        @(negedge clk);
        start = 0;
        chk("b2b_busy", 32'(busy), 1);
        wait_done(40, 0, n, sb);
        chk("b2b2_cycle", n, 16);
        chk("b2b2_quot", 32'(result_low), 3);
        chk("b2b2_rem", 32'(result_high), 0);

        @(negedge clk);
        issue(3'b000, 16'd500, 16'd4);
        wait_done(8, 0, n, sb);
        chk("rst_running", 32'(busy), 1);
        #2 rst = 1;
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_low", 32'(result_low), 0);
        chk("rst_high", 32'(result_high), 0);
        chk("rst_zero", 32'(zero), 0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        issue(3'b111, 16'd2, 16'd3);
        wait_done(40, 0, n, sb);
        chk("post_rst_cycle", n, 17);
        chk("post_rst_low", 32'(result_low), 6);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
# muldiv_sequencer

Multi-cycle controller for the unsigned multiply/divide unit behind the MUL, MULi, DIV and DIVi opcodes. It accepts one operation per Start pulse and runs a radix-2 shift-add multiply or a restoring divide, one bit per clock. While it runs it raises Busy so the pipeline stalls. On completion it pulses Done and presents registered results and flags. It sits beside the ALU and is launched by the control unit. Immediate selection is done upstream, so it always receives two resolved operands.

## Interface
- WIDTH, 16, operand and result width.
- OP_WIDTH, 3, opcode width.
- Clock  in  1  single clock, rising edge.
- Reset  in  1  asynchronous, active-high; clears all state and outputs.
- Start  in  1  launch request; sampled on the rising edge.
- Opcode  in  OP_WIDTH  operation: 111 MUL, 001 MULi, 000 DIV, 010 DIVi; any other code is not a mul/div op.
- OperandA  in  WIDTH  multiplicand or dividend.
- OperandB  in  WIDTH  multiplier or divisor.
- Busy  out  1  operation in progress; the pipeline stalls while high.
- Done  out  1  one-cycle completion pulse.
- ResultLow  out  WIDTH  low half of the product, or the quotient.
- ResultHigh  out  WIDTH  high half of the product, or the remainder.
- Zero  out  1  ResultLow == 0.
- Overflow  out  1  MUL: ResultHigh != 0; DIV: 0.
- DivByZero  out  1  last operation was a divide with OperandB == 0.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE. All outputs reset to 0.
- Accepting a Start:
  - Start is accepted only in IDLE or DONE, and only when Opcode is one of the four mul/div codes.
  - Any other opcode, or Start during RUN, is ignored: no state change, and latched operands are not disturbed.
  - On acceptance, the block latches OperandA, OperandB and the operation kind. MULi is treated as MUL and DIVi as DIV.
  - The iteration counter clears to 0 and the FSM enters RUN.
- Multiply:
  - Uses a 2·WIDTH accumulator.
  - Each RUN cycle examines one multiplier bit, LSB first. When the bit is 1, the multiplicand is added into the upper half. The accumulator then shifts right by one.
  - Arithmetic is unsigned and the full 2·WIDTH product is kept.
- Divide:
  - Uses restoring division with a (WIDTH+1)-bit partial remainder.
  - Each RUN cycle shifts in one dividend bit, MSB first, and trial-subtracts the divisor. If the result is non-negative, the quotient bit is 1 and the difference is kept; otherwise the quotient bit is 0 and the remainder is restored.
- Divide by zero:
  - On acceptance the FSM skips RUN and goes straight to DONE.
  - Results: ResultLow = all ones, ResultHigh = dividend, DivByZero = 1, Overflow = 0.
- Leaving RUN:
  - RUN ends when the counter reaches WIDTH-1 on a rising edge; the FSM then enters DONE.
  - ResultLow, ResultHigh, Zero, Overflow and DivByZero are registered only on entry to DONE.
  - These outputs hold until the next entry to DONE, including throughout a following operation.
- DONE lasts one cycle. Done = 1 and Busy = 0 in that cycle. The FSM returns to IDLE unless a new Start is accepted.
- Reset mid-operation: the FSM returns to IDLE immediately. Busy, Done and all results clear to 0. The operation is abandoned.

## Timing
- Busy and Done are decoded from the state register. Busy = (state == RUN).
- Accepted Start in cycle 0 (normal case):
  - Busy is high in cycles 1 through WIDTH.
  - Done is high in cycle WIDTH+1, which is cycle 17 at the default.
  - Results are valid from that cycle.
- Divide by zero: Done is high in cycle 1 and Busy never rises.
- Back-to-back: a Start accepted in the DONE cycle makes Busy high in the next cycle, with no IDLE gap.
- There is no combinational path from any input to any output.

## Structure
- Opcode encodings go in the shared ISA definitions header used by the control unit. No local copies.
- FSM state encodings are local to this module.
- One natural sub-module is muldiv_step. It is combinational: one multiply step or one divide step, selected by a mode bit. The sequencer owns the registers, the counter and the FSM.

## Test plan
- MUL, A=300, B=300 -> Done at cycle 17. ResultLow=0x5F90, ResultHigh=0x0001, Overflow=1, Zero=0.
- DIVi, A=1000, B=7 -> Done at cycle 17. ResultLow=142, ResultHigh=6, Overflow=0, DivByZero=0.
- DIV, A=0x1234, B=0 -> Done at cycle 1 with Busy never high. ResultLow=0xFFFF, ResultHigh=0x1234, DivByZero=1.
- Ignored starts:
  - Start with Opcode=011 (LUI) -> Busy stays 0, no Done, results unchanged.
  - Start with new operands at cycle 5 of a running MUL -> ignored; the original product is delivered at cycle 17.
- Back-to-back: MULi 0*5 then DIV 9/3 issued in the DONE cycle.
  - First result: ResultLow=0, Zero=1.
  - Second Done arrives 17 cycles later with quotient 3, remainder 0.
- Reset mid-run: assert Reset at cycle 8 of a DIV.
  - Busy, Done and all results are 0 immediately.
  - The FSM returns to IDLE, and a fresh MUL 2*3 then gives ResultLow=6.
